// File: rtl/adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer
// Round-robin scanning controller for the ADC128S052 8-channel 12-bit SPI ADC.
// SCLK, CS_N and DIN are produced from clk with a half-period tick enable.
// The ADC returns in frame N the conversion for the address sent in frame
// N-1, so the first frame after IDLE only primes the address pipeline. Every
// later frame yields one result tagged with the previous frame's address.
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   en, ch_mask    scan enable, channel include mask (bit i -> INi)
//   sample_*       valid/ready result stream (channel tag + 12-bit data)
//   overrun        1-cycle pulse when a held, unaccepted result is replaced
//   busy           sequencer not idle
//   sclk, cs_n,    ADC serial interface (dout already synchronous to clk)
//   din, dout
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module adc_scan_sequencer #(
    parameter int CLK_HZ     = 25000000,
    parameter int SCLK_HZ    = 5000000,
    parameter int PAUSE_SCLK = 10,
    parameter bit INVERT     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  ch_mask,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [2:0]  sample_ch,
    output logic [11:0] sample_data,
    output logic        overrun,
    output logic        busy,
    output logic        sclk,
    output logic        cs_n,
    output logic        din,
    input  logic        dout
);

    localparam int HALF        = CLK_HZ / (2 * SCLK_HZ);
    localparam int DIV_W       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PAUSE_TICKS = 2 * PAUSE_SCLK;
    localparam int PAUSE_W     = $clog2(PAUSE_TICKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_PAUSE} state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [4:0]         r_tog;        // SCLK toggles already made in this frame
    logic               r_frame_end;  // 32nd toggle done, raise cs_n next clk
    logic [PAUSE_W-1:0] r_pause;
    logic [15:0]        r_shift;
    logic [2:0]         r_addr;       // address being sent in this frame
    logic [2:0]         r_prev_addr;  // address whose data this frame carries
    logic               r_prime;      // current frame only primes the ADC
    logic               r_load;       // publish a result on this clk

    logic               w_tick;
    logic               w_start;
    logic [2:0]         w_first;
    logic [2:0]         w_next;
    logic [7:0]         w_din_word;
    logic [11:0]        w_raw;
    logic [11:0]        w_result;

    assign w_tick     = (r_state != S_IDLE) && (r_div == DIV_W'(HALF - 1));
    assign w_start    = en && (ch_mask != 8'd0);
    assign w_din_word = {2'b00, r_addr, 3'b000};
    assign w_raw      = r_shift[11:0];
    assign w_result   = INVERT ? (12'd4095 - w_raw) : w_raw;

    // Channel selection: lowest enabled channel overall, and the lowest
    // enabled channel above r_addr (falling back to the lowest overall, which
    // also covers a single enabled channel repeating).
    // NOTE: every combinational output gets a default before any conditional
    // assignment so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_first = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[i]) w_first = 3'(i);
        end
        w_next = w_first;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[i] && (3'(i) > r_addr)) w_next = 3'(i);
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_tog        <= '0;
            r_frame_end  <= 1'b0;
            r_pause      <= '0;
            r_shift      <= '0;
            r_addr       <= '0;
            r_prev_addr  <= '0;
            r_prime      <= 1'b0;
            r_load       <= 1'b0;
            sclk         <= 1'b1;
            cs_n         <= 1'b1;
            din          <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            r_load  <= 1'b0;

            // Divider free-runs outside IDLE so frame and pause share one grid.
            if (r_state == S_IDLE || w_tick) r_div <= '0;
            else                             r_div <= r_div + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_FRAME;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        r_prime <= 1'b1;
                        r_addr  <= w_first;
                        r_tog   <= '0;
                    end
                end

                S_FRAME: begin
                    if (r_frame_end) begin
                        r_frame_end <= 1'b0;
                        cs_n        <= 1'b1;
                        r_state     <= S_PAUSE;
                        r_pause     <= '0;
                        r_load      <= ~r_prime;
                    end else if (w_tick) begin
                        sclk  <= ~sclk;
                        r_tog <= r_tog + 5'd1;
                        if (sclk) begin
                            // Falling edge: address bits on edges 1..8, zero after.
                            din <= r_tog[4] ? 1'b0 : w_din_word[3'd7 - r_tog[3:1]];
                        end else begin
                            r_shift <= {r_shift[14:0], dout};
                        end
                        if (r_tog == 5'd31) r_frame_end <= 1'b1;
                    end
                end

                S_PAUSE: begin
                    if (w_tick) begin
                        if (r_pause == PAUSE_W'(PAUSE_TICKS - 1)) begin
                            if (w_start) begin
                                r_state     <= S_FRAME;
                                cs_n        <= 1'b0;
                                r_prime     <= 1'b0;
                                r_prev_addr <= r_addr;
                                r_addr      <= w_next;
                                r_tog       <= '0;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            r_pause <= r_pause + 1'b1;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase

            // Newest result always wins; a same-cycle acceptance is not an overrun.
            if (r_load) begin
                sample_data  <= w_result;
                sample_ch    <= r_prev_addr;
                sample_valid <= 1'b1;
                overrun      <= sample_valid && !sample_ready;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule
